// File: rtl/pcm_mic_capture_if.sv
// Sample-path bundle between the I2S mic capture stage and its neighbours:
// mic-facing serial lines, enable, and the valid/ready sample output.
interface pcm_mic_capture_if #(
  parameter int DATA_W = 18
);
  logic              en;
  logic              bclk;
  logic              sdata;
  logic              ws;
  logic [DATA_W-1:0] sample;
  logic              sample_ch;
  logic              sample_valid;
  logic              sample_ready;
  logic              overrun;
  logic              clr_overrun;

  // Capture block side: drives ws and the sample output.
  modport master (
    input  en, bclk, sdata, sample_ready, clr_overrun,
    output ws, sample, sample_ch, sample_valid, overrun
  );

  // Environment side: divider, microphone and sample buffer.
  modport slave (
    output en, bclk, sdata, sample_ready, clr_overrun,
    input  ws, sample, sample_ch, sample_valid, overrun
  );
endinterface

// File: rtl/pcm_mic_capture.sv
// I2S microphone receive stage: edge-detects the divider's bclk in the clk
// domain, generates ws, shifts MSB-first data into samples and hands each
// completed word (tagged with its channel) out on a valid/ready interface.
module pcm_mic_capture #(
  parameter int DATA_W      = 18,
  parameter int SLOT_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  pcm_mic_capture_if.master bus
);

  localparam int BCNT_W = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(SLOT_W - 1);
  localparam logic [BCNT_W-1:0] BCNT_DATA = BCNT_W'(DATA_W);
  localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_bclk_sync;
  logic [SYNC_STAGES-1:0] r_sdata_sync;
  logic                   r_bclk_prev;
  logic                   r_rise;
  logic                   r_fall;

  state_t            r_state, w_state_next;
  logic [BCNT_W-1:0] r_bcnt, w_bcnt_next;
  logic              r_ws, w_ws_next;
  logic [DATA_W-1:0] r_shift, w_shift_next;
  logic [DATA_W-1:0] w_shift_in;
  logic              w_sdata;
  logic              w_done;

  logic [DATA_W-1:0] r_sample;
  logic              r_sample_ch;
  logic              r_valid;
  logic              r_overrun;

  assign w_sdata = r_sdata_sync[SYNC_STAGES-1];

  // Shift register with the newest synchronised data bit appended at the LSB.
  generate
    if (DATA_W > 1) begin : g_shift_wide
      assign w_shift_in = {r_shift[DATA_W-2:0], w_sdata};
    end else begin : g_shift_one
      assign w_shift_in = w_sdata;
    end
  endgenerate

  // Synchronise bclk/sdata and register one-clk rise/fall pulses of bclk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bclk_sync  <= '0;
      r_sdata_sync <= '0;
      r_bclk_prev  <= 1'b0;
      r_rise       <= 1'b0;
      r_fall       <= 1'b0;
    end else begin
      r_bclk_sync  <= {r_bclk_sync[SYNC_STAGES-2:0], bus.bclk};
      r_sdata_sync <= {r_sdata_sync[SYNC_STAGES-2:0], bus.sdata};
      r_bclk_prev  <= r_bclk_sync[SYNC_STAGES-1];
      r_rise       <= r_bclk_sync[SYNC_STAGES-1] & ~r_bclk_prev;
      r_fall       <= ~r_bclk_sync[SYNC_STAGES-1] & r_bclk_prev;
    end
  end

  // Framing state, bit counter, ws and shift register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_bcnt  <= '0;
      r_ws    <= 1'b0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_next;
      r_bcnt  <= w_bcnt_next;
      r_ws    <= w_ws_next;
      r_shift <= w_shift_next;
    end
  end

  // Next-state: align to the first bclk fall, then count slots and capture
  // bits 1..DATA_W of each slot (bit 0 is the one-bclk I2S delay).
  always_comb begin
    w_state_next = r_state;
    w_bcnt_next  = r_bcnt;
    w_ws_next    = r_ws;
    w_shift_next = r_shift;
    w_done       = 1'b0;
    if (!bus.en) begin
      w_state_next = ST_IDLE;
      w_bcnt_next  = '0;
      w_ws_next    = 1'b0;
      w_shift_next = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_bcnt_next  = '0;
          w_ws_next    = 1'b0;
          w_state_next = ST_ALIGN;
        end
        ST_ALIGN: begin
          if (r_fall) begin
            w_state_next = ST_RUN;
            w_bcnt_next  = '0;
            w_ws_next    = 1'b0;
          end
        end
        ST_RUN: begin
          if (r_fall) begin
            if (r_bcnt == BCNT_LAST) begin
              w_bcnt_next = '0;
              w_ws_next   = ~r_ws;
            end else begin
              w_bcnt_next = r_bcnt + BCNT_ONE;
            end
          end
          if (r_rise && (r_bcnt >= BCNT_ONE) && (r_bcnt <= BCNT_DATA)) begin
            w_shift_next = w_shift_in;
            w_done       = (r_bcnt == BCNT_DATA);
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // Output holding register with valid/ready handshake and sticky overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sample    <= '0;
      r_sample_ch <= 1'b0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_done) begin
        if (!r_valid || bus.sample_ready) begin
          r_sample    <= w_shift_in;
          r_sample_ch <= r_ws;
          r_valid     <= 1'b1;
        end
      end else if (r_valid && bus.sample_ready) begin
        r_valid <= 1'b0;
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_done && r_valid && !bus.sample_ready) begin
        r_overrun <= 1'b1;
      end else if (bus.clr_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign bus.ws           = r_ws;
  assign bus.sample       = r_sample;
  assign bus.sample_ch    = r_sample_ch;
  assign bus.sample_valid = r_valid;
  assign bus.overrun      = r_overrun;

endmodule

// File: tb/tb_pcm_mic_capture.sv
// Bench for pcm_mic_capture: a behavioural I2S mic drives known/random words
// by slot, a cycle-level reference predicts ws and the output handshake, and
// every clk the DUT outputs are compared against it, plus directed checks.
module tb_pcm_mic_capture;
  localparam int DATA_W = 18;
  localparam int SLOT_W = 32;
  localparam int SYNC   = 2;
  localparam int LAT    = SYNC + 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pcm_mic_capture_if #(.DATA_W(DATA_W)) bus ();

  pcm_mic_capture #(
    .DATA_W(DATA_W), .SLOT_W(SLOT_W), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int                at;
    logic [DATA_W-1:0] w;
    bit                ch;
  } comp_t;

  comp_t             comp_q[$];
  int                ws_q[$];
  int                cyc = 0;
  logic [DATA_W-1:0] slot_word [64];
  int                comp_edge [64];
  int                fall_idx = -1;
  bit                mic_on   = 1'b0;

  // Reference state of the outputs, advanced at each clk edge.
  bit                m_valid = 0, m_ch = 0, m_ovr = 0, m_ws = 0;
  logic [DATA_W-1:0] m_sample = '0;

  // Monitor bookkeeping.
  int                n_loads = 0, ld_cyc = 0, ws_rise = 0, ws_hi = 0, ws_per = 0;
  logic [DATA_W-1:0] ld_word = '0;
  bit                ld_ch = 0;

  // Bit clock at clk/8 and the microphone: data for bit k of a slot is driven
  // after the k-th fall counted from the alignment fall.
  initial begin
    int ph;
    int b;
    int s;
    comp_t c;
    ph = 0;
    bus.bclk  = 1'b0;
    bus.sdata = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ph = (ph + 1) % 8;
      if (ph == 0) begin
        bus.bclk = 1'b1;
        if (mic_on && fall_idx >= 0 && (fall_idx % SLOT_W) == DATA_W) begin
          s = fall_idx / SLOT_W;
          c.at = cyc + LAT;
          c.w  = slot_word[s];
          c.ch = bit'(s % 2);
          comp_q.push_back(c);
          comp_edge[s] = cyc + LAT;
        end
      end else if (ph == 4) begin
        bus.bclk = 1'b0;
        if (mic_on) begin
          fall_idx++;
          b = fall_idx % SLOT_W;
          s = fall_idx / SLOT_W;
          if (b == 0 && fall_idx > 0) ws_q.push_back(cyc + LAT);
          if (b >= 1 && b <= DATA_W) bus.sdata = slot_word[s][DATA_W-b];
          else bus.sdata = 1'($urandom);
        end else begin
          bus.sdata = 1'($urandom);
        end
      end
    end
  end

  // Reference model of ws and the output handshake, stepped at each edge.
  initial begin
    bit    rdy, clr, done, drop;
    comp_t c;
    forever begin
      @(posedge clk);
      cyc++;
      rdy  = bus.sample_ready;
      clr  = bus.clr_overrun;
      done = 0;
      if (!reset) begin
        m_valid = 0; m_ch = 0; m_ovr = 0; m_ws = 0; m_sample = '0;
      end else begin
        if (!bus.en) m_ws = 0;
        while (ws_q.size() > 0 && ws_q[0] <= cyc) begin
          void'(ws_q.pop_front());
          m_ws = ~m_ws;
        end
        if (comp_q.size() > 0 && comp_q[0].at <= cyc) begin
          c = comp_q.pop_front();
          done = 1;
        end
        drop = done && m_valid && !rdy;
        if (done) begin
          if (!m_valid || rdy) begin
            m_sample = c.w; m_ch = c.ch; m_valid = 1;
          end
        end else if (m_valid && rdy) begin
          m_valid = 0;
        end
        if (drop) m_ovr = 1;
        else if (clr) m_ovr = 0;
      end
    end
  end

  // Per-cycle comparison against the reference, plus load and ws timing logs.
  initial begin
    bit pv, pws;
    pv = 0; pws = 0;
    forever begin
      @(negedge clk);
      check("cyc_valid",  bus.sample_valid, reset ? m_valid  : 1'b0);
      check("cyc_sample", bus.sample,       reset ? m_sample : '0);
      check("cyc_ch",     bus.sample_ch,    reset ? m_ch     : 1'b0);
      check("cyc_ovr",    bus.overrun,      reset ? m_ovr    : 1'b0);
      check("cyc_ws",     bus.ws,           reset ? m_ws     : 1'b0);
      if (bus.sample_valid && !pv) begin
        n_loads++; ld_cyc = cyc; ld_word = bus.sample; ld_ch = bus.sample_ch;
      end
      if (bus.ws && !pws) begin
        if (ws_rise > 0) ws_per = cyc - ws_rise;
        ws_rise = cyc;
      end
      if (!bus.ws && pws) ws_hi = cyc - ws_rise;
      pv  = bus.sample_valid;
      pws = bus.ws;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_fall(input int n);
    int guard;
    guard = 0;
    while (fall_idx < n && guard < 20000) begin
      tick();
      guard++;
    end
    check("reach_fall", fall_idx >= n, 1);
  endtask

  task automatic wait_cyc(input int c);
    int guard;
    guard = 0;
    while (cyc < c && guard < 2000) begin
      tick();
      guard++;
    end
    check("reach_cyc", cyc, c);
  endtask

  // Assert en just after a raw bclk rise so the next fall is the alignment fall.
  task automatic enable_capture();
    int   guard;
    logic last;
    guard = 0;
    last  = bus.bclk;
    tick();
    while (!(bus.bclk && !last) && guard < 20) begin
      last = bus.bclk;
      tick();
      guard++;
    end
    check("bclk_rise_seen", guard < 20, 1);
    fall_idx = -1;
    mic_on   = 1'b1;
    bus.en   = 1'b1;
  endtask

  initial begin
    int nl;
    bus.en = 1'b0; bus.sample_ready = 1'b0; bus.clr_overrun = 1'b0;
    for (int i = 0; i < 64; i++) slot_word[i] = DATA_W'($urandom);
    slot_word[0] = 18'h2A5A5;
    slot_word[1] = 18'h15A5A;
    slot_word[2] = 18'h00001;
    slot_word[3] = 18'h3FFFF;

    // Reset and idle
    tick(5);
    check("rst_valid", bus.sample_valid, 0);
    check("rst_ws", bus.ws, 0);
    reset = 1'b1;
    tick(200);
    check("idle_ws", bus.ws, 0);
    check("idle_valid", bus.sample_valid, 0);
    check("idle_ovr", bus.overrun, 0);
    check("idle_sample", bus.sample, 0);

    // Left then right capture with ready high
    bus.sample_ready = 1'b1;
    enable_capture();
    wait_fall(DATA_W + 2);
    tick(6);
    check("left_word", ld_word, 18'h2A5A5);
    check("left_ch", ld_ch, 0);
    check("left_latency", ld_cyc, comp_edge[0]);
    wait_fall(SLOT_W + DATA_W + 2);
    tick(6);
    check("right_word", ld_word, 18'h15A5A);
    check("right_ch", ld_ch, 1);

    // Backpressure across two completed words
    wait_fall(2 * SLOT_W + 4);
    bus.sample_ready = 1'b0;
    wait_fall(3 * SLOT_W + DATA_W + 2);
    tick(6);
    check("bp_sample", bus.sample, 18'h00001);
    check("bp_valid", bus.sample_valid, 1);
    check("bp_ovr", bus.overrun, 1);
    check("ws_high_clk", ws_hi, SLOT_W * 8);
    check("ws_period_clk", ws_per, 2 * SLOT_W * 8);
    bus.sample_ready = 1'b1;
    tick();
    bus.sample_ready = 1'b0;
    check("bp_drop_valid", bus.sample_valid, 0);
    bus.clr_overrun = 1'b1;
    tick();
    bus.clr_overrun = 1'b0;
    check("bp_clr_ovr", bus.overrun, 0);

    // Accept and complete in the same cycle
    wait_fall(5 * SLOT_W + DATA_W);
    tick(4);
    check("simul_held", bus.sample, slot_word[4]);
    wait_cyc(comp_edge[5] - 1);
    bus.sample_ready = 1'b1;
    tick();
    bus.sample_ready = 1'b0;
    check("simul_valid", bus.sample_valid, 1);
    check("simul_sample", bus.sample, slot_word[5]);
    check("simul_ch", bus.sample_ch, 1);
    check("simul_ovr", bus.overrun, 0);
    bus.sample_ready = 1'b1;
    tick(2);

    // Random ready and overrun clears over many slots
    while (fall_idx < 16 * SLOT_W) begin
      tick();
      bus.sample_ready = 1'($urandom);
      bus.clr_overrun  = ($urandom_range(15) == 0);
    end
    bus.sample_ready = 1'b1;
    bus.clr_overrun  = 1'b0;
    tick(8);

    // Mid-word disable in a right slot
    wait_fall(17 * SLOT_W + 10);
    check("dis_ws_before", bus.ws, 1);
    bus.en = 1'b0;
    mic_on = 1'b0;
    comp_q.delete();
    ws_q.delete();
    nl = n_loads;
    tick();
    check("dis_ws_after", bus.ws, 0);
    tick(300);
    check("dis_no_load", n_loads, nl);
    check("dis_valid", bus.sample_valid, 0);

    // Re-enable: first word only after a full aligned left slot
    slot_word[0] = DATA_W'($urandom);
    slot_word[1] = DATA_W'($urandom);
    enable_capture();
    wait_fall(DATA_W + 2);
    tick(6);
    check("reen_loads", n_loads, nl + 1);
    check("reen_word", ld_word, slot_word[0]);
    check("reen_ch", ld_ch, 0);
    check("reen_latency", ld_cyc, comp_edge[0]);

    // Asynchronous reset mid-word
    wait_fall(SLOT_W + 5);
    check("rst_ws_before", bus.ws, 1);
    reset  = 1'b0;
    mic_on = 1'b0;
    bus.en = 1'b0;
    comp_q.delete();
    ws_q.delete();
    #1;
    check("arst_ws", bus.ws, 0);
    check("arst_valid", bus.sample_valid, 0);
    check("arst_sample", bus.sample, 0);
    check("arst_ch", bus.sample_ch, 0);
    check("arst_ovr", bus.overrun, 0);
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pcm_mic_capture.md
Name: pcm_mic_capture

Overview:
- Serial receive stage directly downstream of the bit-clock divider in the PCM microphone path.
- Consumes the divider's bclk, generates word-select (ws) for an I2S-format MEMS microphone, and shifts the mic's serial data into parallel samples.
- Presents each completed sample, tagged with its channel, on a valid/ready interface to the sample buffer.
- All logic runs in the system clk domain; bclk is treated as a data signal and is edge-detected, not used as a clock.

Parameters:
DATA_W, 18, captured bits per sample (MSB first); legal range 1..SLOT_W-1.
SLOT_W, 32, bclk periods per channel slot (half ws frame).
SYNC_STAGES, 2, flip-flop stages synchronising bclk and sdata; minimum 2.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
en  input  1  capture enable; same signal that enables the bclk divider.
bclk  input  1  bit clock from the frequency divider; period >= 4 clk.
sdata  input  1  serial data from the microphone.
ws  output  1  word select to the microphone: 0 = left slot, 1 = right slot.
sample  output  DATA_W  captured sample, MSB-first order preserved.
sample_ch  output  1  channel of the sample: 0 = left, 1 = right.
sample_valid  output  1  sample/sample_ch hold a word not yet accepted.
sample_ready  input  1  consumer accepts the word this cycle when valid is high.
overrun  output  1  sticky flag: a completed word was dropped.
clr_overrun  input  1  synchronous clear of overrun.

Behaviour:
- Reset (reset=0, asynchronous): ws, sample, sample_ch, sample_valid and overrun = 0; bit counter, shift register and state cleared.
- Synchronisation and edge detect:
  - bclk and sdata each pass through SYNC_STAGES flops.
  - rise = synced bclk 1 with previous 0; fall = synced bclk 0 with previous 1. Each is a one-clk pulse.
- State machine:
  - IDLE: ws=0, bcnt=0. Go to ALIGN when en=1.
  - ALIGN: wait for the first fall, then go to RUN with bcnt=0 and ws=0. No capture occurs in ALIGN.
  - RUN, on each fall: if bcnt==SLOT_W-1, then bcnt<=0 and ws toggles; otherwise bcnt<=bcnt+1.
  - RUN, on each rise with 1<=bcnt<=DATA_W: shift_reg <= {shift_reg[DATA_W-2:0], sdata_sync}. This gives the one-bclk I2S delay after the ws edge.
  - RUN, rise with bcnt==DATA_W: word completes. The completed word is the shifted value including this bit; its channel is the current ws.
  - Bits at bcnt>DATA_W and at bcnt=0 are ignored.
  - Any state: en=0 -> IDLE on the next clk. Counter, ws and shift register clear; the partial word is discarded. A pending output word stays valid.
- Output handshake:
  - On word completion, the word loads into sample/sample_ch and sample_valid=1 on the next clk edge, i.e. 1 clk after the rise pulse.
  - sample_valid stays high, with sample and sample_ch stable, until a cycle with sample_ready=1. It then drops on the next edge unless a new word loads in that same edge.
  - Completion while valid=1 and ready=1: the new word loads and valid stays 1. No overrun.
  - Completion while valid=1 and ready=0: the new word is dropped, the held word is unchanged, and overrun<=1.
  - clr_overrun=1 clears overrun. If clear and a new drop occur in the same cycle, the drop wins (overrun stays 1).
- Latency: raw bclk edge -> rise pulse = SYNC_STAGES+1 clk; last data bit rise -> sample_valid = SYNC_STAGES+2 clk.
- ws period: 2*SLOT_W bclk periods with exactly 50% duty. ws changes only on fall pulses.

Test Plan:
Bench setup for all scenarios: DATA_W=18, SLOT_W=32, bclk = clk/8.
1. Reset and idle: reset=0 for 5 clk, then reset=1 with en=0 for 200 clk -> ws, sample_valid and overrun remain 0; sample=0.
2. Left capture: en=1, sample_ready=1; mic model drives 0x2A5A5 MSB-first on bits 1..18 of the ws=0 slot -> one-clk valid pulse with sample=0x2A5A5, sample_ch=0, exactly SYNC_STAGES+2 clk after the 18th bit's raw bclk rise.
3. Right capture and framing: next slot drives 0x15A5A -> sample=0x15A5A, sample_ch=1; ws high time = 32 bclk = 256 clk; ws period = 512 clk.
4. Backpressure: sample_ready=0 across two completed words (0x00001, then 0x3FFFF) -> sample holds 0x00001, overrun=1. Raise ready -> valid drops after 1 cycle. Pulse clr_overrun -> overrun=0.
5. Simultaneous accept and complete: assert ready in the exact cycle a new word completes -> new word loaded, valid stays 1, overrun stays 0.
6. Mid-word disable and reset: en=0 at bcnt=10 -> ws=0 on the next clk and no valid for the partial word. Re-enable -> first valid only after a full aligned left slot. reset=0 mid-word -> all outputs 0 immediately.
